// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment driver: shadows the display value, scans one digit
// per prescaler slot, and applies PWM brightness plus optional leading-zero blanking.
module seven_seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 10
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic [4*NUM_DIGITS-1:0]   din,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      en,
    input  logic                      blank_lz,
    input  logic [3:0]                brightness,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     dig_sel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_din;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig_sel;

    logic [3:0]              w_nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_on;
    logic                    w_suppress;
    logic [3:0]              w_cur_nibble;
    logic [6:0]              w_hex;

    // w_upper_zero[i]: every nibble from i up to the most significant is zero
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nibble[gi]     = r_shadow_din[4*gi +: 4];
            assign w_onehot[gi]     = (r_idx == IDX_W'(gi));
            assign w_upper_zero[gi] = (r_shadow_din[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        w_on         = en && (r_cnt[DIV_WIDTH-1 -: 4] <= brightness);
        w_cur_nibble = w_nibble[r_idx];
        w_suppress   = blank_lz && (r_idx != '0) && w_upper_zero[r_idx];
        w_hex        = 7'h7F;
        case (w_cur_nibble)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            default: w_hex = 7'h0E;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow_din <= '0;
            r_shadow_dp  <= '0;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_dig_sel    <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
            if (&r_cnt) begin
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS-1)) ? '0 : r_idx + IDX_W'(1);
            end
            if (load) begin
                r_shadow_din <= din;
                r_shadow_dp  <= dp_in;
            end
            // Outputs use pre-edge state so latency is exactly one cycle
            if (w_on) begin
                r_dig_sel <= w_onehot;
                r_seg     <= w_suppress ? 7'h7F : w_hex;
                r_dp      <= ~r_shadow_dp[r_idx];
            end else begin
                r_dig_sel <= '0;
                r_seg     <= 7'h7F;
                r_dp      <= 1'b1;
            end
        end
    end

    assign seg     = r_seg;
    assign dp      = r_dp;
    assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 32-cycle slots) with a cycle-level
// reference model feeding a scoreboard, plus explicit constant checks.
module tb_seven_seg_scan;

    localparam int N  = 4;
    localparam int DW = 5;

    logic        CLK = 1'b0;
    logic        resetn, load, en, blank_lz;
    logic [15:0] din;
    logic [3:0]  dp_in, brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
    } out_t;

    out_t        sb_q[$];
    logic [4:0]  m_cnt = '0;
    logic [1:0]  m_idx = '0;
    logic [15:0] m_din = '0;
    logic [3:0]  m_dp  = '0;
    logic [6:0]  hex_tbl [16];

    always #5 CLK = ~CLK;

    seven_seg_scan #(.NUM_DIGITS(N), .DIV_WIDTH(DW)) dut (
        .CLK(CLK), .resetn(resetn), .din(din), .dp_in(dp_in), .load(load),
        .en(en), .blank_lz(blank_lz), .brightness(brightness),
        .seg(seg), .dp(dp), .dig_sel(dig_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic out_t model_out();
        out_t       o;
        logic       on;
        logic       sup;
        logic [3:0] nib;
        o   = '{seg: 7'h7F, dp: 1'b1, sel: 4'b0000};
        on  = en && (m_cnt[4:1] <= brightness);
        nib = m_din[m_idx*4 +: 4];
        sup = blank_lz && (m_idx != 2'd0) && ((m_din >> (m_idx*4)) == 16'h0);
        if (resetn && on) begin
            o.sel = 4'b0001 << m_idx;
            o.seg = sup ? 7'h7F : hex_tbl[nib];
            o.dp  = ~m_dp[m_idx];
        end
        return o;
    endfunction

    task automatic model_update();
        if (!resetn) begin
            m_cnt = '0; m_idx = '0; m_din = '0; m_dp = '0;
        end else begin
            if (load) begin
                m_din = din;
                m_dp  = dp_in;
            end
            if (&m_cnt) m_idx = (m_idx == 2'd3) ? 2'd0 : m_idx + 2'd1;
            m_cnt = m_cnt + 5'd1;
        end
    endtask

    // One clock: predict, clock, then compare DUT against the popped prediction
    task automatic step();
        out_t e;
        sb_q.push_back(model_out());
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        e = sb_q.pop_front();
        chk("scoreboard", {seg, dp, dig_sel}, e);
    endtask

    initial begin
        int lit;
        hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        resetn = 1'b0; load = 1'b0; en = 1'b1; blank_lz = 1'b0;
        din = '0; dp_in = '0; brightness = 4'd15;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_seg", seg, 7'h7F);
            chk("rst_dp", dp, 1'b1);
            chk("rst_sel", dig_sel, 4'b0000);
        end
        resetn = 1'b1;

        // Full-brightness scan order, 32 cycles per digit
        for (int d = 0; d < 5; d++) begin
            for (int i = 0; i < 32; i++) begin
                step();
                chk("scan_sel", dig_sel, 4'b0001 << (d % 4));
            end
        end

        // Decode and decimal point
        din = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (dig_sel == 4'b0001) chk("dec_4", seg, 7'h19);
            if (dig_sel == 4'b0010) chk("dec_3", seg, 7'h30);
            chk("dp_pos", dp, (dig_sel == 4'b0100) ? 1'b0 : 1'b1);
        end

        // Brightness duty: any 128-cycle window covers each cnt value four times
        brightness = 4'd3; lit = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (dig_sel != 4'b0000) lit++;
        end
        chk("duty_b3", lit, 32);
        brightness = 4'd0; lit = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (dig_sel != 4'b0000) lit++;
        end
        chk("duty_b0", lit, 8);

        // Leading-zero suppression
        brightness = 4'd15; blank_lz = 1'b1; din = 16'h0050; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 128; i++) begin
            step();
            chk("lz_nonzero_sel", (dig_sel != 4'b0000), 1'b1);
            case (dig_sel)
                4'b1000: chk("lz_d3", seg, 7'h7F);
                4'b0100: chk("lz_d2", seg, 7'h7F);
                4'b0010: chk("lz_d1", seg, 7'h12);
                4'b0001: chk("lz_d0", seg, 7'h40);
                default: chk("lz_sel", dig_sel, 4'b0001);
            endcase
        end
        din = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 128; i++) begin
            step();
            chk("lz_zero", seg, (dig_sel == 4'b0001) ? 7'h40 : 7'h7F);
        end

        // Load coincident with the digit 1 -> 2 advance
        blank_lz = 1'b0;
        for (int i = 0; i < 200 && !(m_idx == 2'd1 && m_cnt == 5'd31); i++) step();
        chk("wait_adv", {m_idx, m_cnt}, {2'd1, 5'd31});
        din = 16'h0A00; load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("adv_sel", dig_sel, 4'b0100);
        chk("adv_seg", seg, 7'h08);

        // Enable off for 40 cycles; counter keeps running
        en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("en0_sel", dig_sel, 4'b0000);
            chk("en0_seg", seg, 7'h7F);
        end
        en = 1'b1;
        step();
        chk("en_resume", dig_sel, 4'b1000);

        // Mid-scan reset pulse
        for (int i = 0; i < 200 && dig_sel != 4'b0100; i++) step();
        chk("wait_d2", dig_sel, 4'b0100);
        resetn = 1'b0;
        step();
        chk("pulse_sel", dig_sel, 4'b0000);
        chk("pulse_seg", seg, 7'h7F);
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("post_rst_sel", dig_sel, 4'b0001);
            chk("post_rst_seg", seg, 7'h40);
        end
        step();
        chk("post_rst_next", dig_sel, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 The block SHALL have parameter DIV_WIDTH, default 10, scan prescaler width in bits (legal >= 5); one digit slot lasts 2^DIV_WIDTH cycles.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 din  input  4*NUM_DIGITS  hex nibbles; din[3:0] is digit 0, the least significant digit.
REQ-006 dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-007 load  input  1  capture strobe for din and dp_in.
REQ-008 en  input  1  display enable; 0 blanks all outputs.
REQ-009 blank_lz  input  1  leading-zero suppression enable.
REQ-010 brightness  input  4  duty level 0..15.
REQ-011 seg  output  7  segments a..g on bits 0..6, active-low.
REQ-012 dp  output  1  decimal point, active-low.
REQ-013 dig_sel  output  NUM_DIGITS  digit enable, one-hot or zero, active-high.

Function
REQ-014 Shadow registers SHALL capture din and dp_in on every cycle with load=1 and hold them otherwise; the display SHALL use only the shadow contents.
REQ-015 Prescaler cnt (DIV_WIDTH bits) SHALL increment every cycle and wrap from all-ones to 0.
REQ-016 Digit index idx SHALL advance on cycles where cnt is all-ones: NUM_DIGITS-1 -> 0, otherwise idx+1.
REQ-017 The on-phase SHALL be defined as en=1 and cnt[DIV_WIDTH-1:DIV_WIDTH-4] <= brightness; brightness=15 is 100 % duty and brightness=0 is 1/16 duty.
REQ-018 Outputs SHALL be registered and SHALL reflect idx, cnt, and the shadow registers from the previous cycle, giving a fixed 1-cycle latency.
REQ-019 In the on-phase: dig_sel SHALL be one-hot at bit idx; seg SHALL be the inverted hex decode of shadow nibble idx (0-9, A, b, C, d, E, F); dp SHALL be ~shadow_dp[idx].
REQ-020 In the off-phase: seg SHALL be 7'h7F, dp SHALL be 1, and dig_sel SHALL be 0.
REQ-021 Leading-zero suppression: with blank_lz=1, digit i>0 SHALL be suppressed when shadow nibbles NUM_DIGITS-1 down to i are all zero; digit 0 SHALL never be suppressed.
REQ-022 For a suppressed digit, seg SHALL be 7'h7F, while dig_sel and dp SHALL behave as in REQ-019.
REQ-023 When load and the idx advance occur in the same cycle, the new shadow value SHALL appear on the next output cycle for the new idx.
REQ-024 en=0 SHALL NOT stop cnt or idx; scanning phase SHALL continue unchanged.
REQ-025 The block SHALL generate no cycle where more than one dig_sel bit is high.

Reset
REQ-026 While resetn=0 at a clock edge: cnt=0, idx=0, shadow din=0, shadow dp=0, seg=7'h7F, dp=1, dig_sel=0.
REQ-027 Reset asserted mid-scan SHALL take effect at the next edge with no partial-slot completion; after release, scanning SHALL restart at digit 0 with a full slot.

Verification (NUM_DIGITS=4, DIV_WIDTH=5)
REQ-028 Reset held 3 cycles, en=1, brightness=15 -> seg=7F, dp=1, dig_sel=0 during reset; dig_sel=0001 from the 1st edge after release for 32 cycles, then 0010, 0100, 1000, 0001.
REQ-029 load din=16'h1234, dp_in=4'b0100, blank_lz=0 -> seg=7'h19 (4) with dig_sel=0001; seg=7'h30 (3) with dig_sel=0010; dp=0 only while dig_sel=0100.
REQ-030 brightness=3 -> each digit lit for 8 consecutive cycles (cnt 0..7, output-delayed by 1) out of 32; brightness=0 -> 2 of 32 cycles lit.
REQ-031 blank_lz=1, din=16'h0050 -> digits 3 and 2 show seg=7F with dig_sel still asserted, digit 1 shows 5 (7'h12), digit 0 shows 0 (7'h40); din=0 -> only digit 0 shows 0.
REQ-032 load=1 coincident with the digit 1->2 advance -> digit 2 displays the new nibble in its first output cycle; en=0 for 40 cycles, then en=1 -> outputs blank during en=0, and the scan resumes at the digit implied by the uninterrupted counter.
REQ-033 resetn pulsed low for 1 cycle while dig_sel=0100 -> next output cycle is blank; dig_sel=0001 follows for 32 cycles; shadow is cleared, so digit 0 shows 0.
